// File: rtl/p4_router_egr_replicator.sv
// p4_router_egr_replicator: replicates the egress AXIS bus onto NUM_PORTS ports (unicast index or multicast mask).
// Per-port forward / drop counters are built only when P4_ROUTER_EGR_REPLICATOR_CNT_EN is defined.
//
// state   | meaning
// ST_SOF  | next input beat is the first beat of a packet
// ST_FWD  | forwarding the rest of a packet to r_dmask
// ST_DROP | consuming and discarding the rest of a packet
module p4_router_egr_replicator #(
  parameter int DATA_BYTES = 8,
  parameter int NUM_PORTS  = 4,
  parameter int MCAST_MODE = 0,
  parameter int USER_WIDTH = (MCAST_MODE != 0) ? NUM_PORTS
                                               : ((NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1),
  parameter int CNT_WIDTH  = 32
) (
  input  logic                                clk,
  input  logic                                aresetn,
  input  logic [DATA_BYTES*8-1:0]             s_tdata,
  input  logic [DATA_BYTES-1:0]               s_tkeep,
  input  logic                                s_tlast,
  input  logic [USER_WIDTH-1:0]               s_tuser,
  input  logic                                s_tvalid,
  output logic                                s_tready,
  output logic [NUM_PORTS*DATA_BYTES*8-1:0]   m_tdata,
  output logic [NUM_PORTS*DATA_BYTES-1:0]     m_tkeep,
  output logic [NUM_PORTS-1:0]                m_tlast,
  output logic [NUM_PORTS-1:0]                m_tvalid,
  input  logic [NUM_PORTS-1:0]                m_tready,
  input  logic [NUM_PORTS-1:0]                port_enable,
  output logic                                drop_pulse,
  input  logic                                cnt_clear,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]      fwd_cnt,
  output logic [CNT_WIDTH-1:0]                drop_cnt
);

  localparam int DW = DATA_BYTES * 8;
  localparam int XW = (USER_WIDTH > NUM_PORTS) ? USER_WIDTH : NUM_PORTS;

  typedef enum logic [1:0] {ST_SOF, ST_FWD, ST_DROP} state_t;

  state_t                 r_state, w_state_nxt;
  logic [1:0]             r_rst_sync;
  logic                   r_live;
  logic [NUM_PORTS-1:0]   r_dmask, r_pend;
  logic [DW-1:0]          r_data;
  logic [DATA_BYTES-1:0]  r_keep;
  logic                   r_last;
  logic                   r_drop_pulse;

  logic [XW-1:0]          w_tuser_ext;
  logic [NUM_PORTS-1:0]   w_raw, w_sof_mask, w_load_mask;
  logic                   w_drain_ok, w_load, w_drop_evt;

  assign r_live      = r_rst_sync[1];
  assign w_tuser_ext = XW'(s_tuser);
  assign w_sof_mask  = w_raw & port_enable;
  assign w_drain_ok  = ((r_pend & ~m_tready) == '0);

  // Unicast indices >= NUM_PORTS match no port and decode to an empty mask.
  always_comb begin
    w_raw = '0;
    if (MCAST_MODE != 0) begin
      w_raw = w_tuser_ext[NUM_PORTS-1:0];
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_tuser_ext == XW'(i)) w_raw[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_rst_sync <= 2'b00;
      r_state    <= ST_SOF;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
      r_state    <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    s_tready    = 1'b0;
    w_load      = 1'b0;
    w_drop_evt  = 1'b0;
    w_load_mask = r_dmask;
    case (r_state)
      ST_SOF: begin
        w_load_mask = w_sof_mask;
        if (w_sof_mask == '0) begin
          s_tready   = r_live;
          w_drop_evt = s_tvalid & r_live;
          if (w_drop_evt && !s_tlast) w_state_nxt = ST_DROP;
        end else begin
          s_tready = r_live & w_drain_ok;
          w_load   = s_tvalid & r_live & w_drain_ok;
          if (w_load && !s_tlast) w_state_nxt = ST_FWD;
        end
      end
      ST_FWD: begin
        s_tready = r_live & w_drain_ok;
        w_load   = s_tvalid & r_live & w_drain_ok;
        if (w_load && s_tlast) w_state_nxt = ST_SOF;
      end
      ST_DROP: begin
        s_tready = r_live;
        if (s_tvalid && r_live && s_tlast) w_state_nxt = ST_SOF;
      end
      default: w_state_nxt = ST_SOF;
    endcase
  end

  // The output register only reloads once every selected port has taken the previous beat.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_pend       <= '0;
      r_dmask      <= '0;
      r_data       <= '0;
      r_keep       <= '0;
      r_last       <= 1'b0;
      r_drop_pulse <= 1'b0;
    end else begin
      r_drop_pulse <= w_drop_evt;
      if (w_load) begin
        r_pend <= w_load_mask;
        r_data <= s_tdata;
        r_keep <= s_tkeep;
        r_last <= s_tlast;
      end else begin
        r_pend <= r_pend & ~m_tready;
      end
      if (w_load && r_state == ST_SOF) r_dmask <= w_sof_mask;
    end
  end

  assign m_tvalid   = r_pend;
  assign m_tdata    = {NUM_PORTS{r_data}};
  assign m_tkeep    = {NUM_PORTS{r_keep}};
  assign m_tlast    = {NUM_PORTS{r_last}};
  assign drop_pulse = r_drop_pulse;

`ifdef P4_ROUTER_EGR_REPLICATOR_CNT_EN
  logic [NUM_PORTS-1:0][CNT_WIDTH-1:0] r_fwd_cnt;
  logic [CNT_WIDTH-1:0]                r_drop_cnt;

  // Saturating counters; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_fwd_cnt  <= '0;
      r_drop_cnt <= '0;
    end else if (cnt_clear) begin
      r_fwd_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (r_pend[i] && m_tready[i] && r_last && (r_fwd_cnt[i] != '1))
          r_fwd_cnt[i] <= r_fwd_cnt[i] + CNT_WIDTH'(1);
      end
      if (w_drop_evt && (r_drop_cnt != '1))
        r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
    end
  end

  assign fwd_cnt  = r_fwd_cnt;
  assign drop_cnt = r_drop_cnt;
`else
  logic w_unused_cnt_clear;
  assign w_unused_cnt_clear = cnt_clear;
  assign fwd_cnt  = '0;
  assign drop_cnt = '0;
`endif

endmodule
